// File: rtl/cache_mem_arbiter.sv
// Shares the single multicycle main memory between the I-cache and D-cache miss paths:
// round-robin grant, 8-word block fill sequencing, and single-cycle D-cache write-through.
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic              dcache_wr,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              icache_busy,
  output logic              dcache_busy,
  output logic              icache_fill_we,
  output logic              dcache_fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              icache_done,
  output logic              dcache_done
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_WORDS = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:OFF_W] base_q, base_d;
  logic [CNT_W-1:0]      iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]      rtn_cnt_q, rtn_cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  fill_active;
  logic                  fill_ret;
  logic                  grant_i;
  logic                  unused_addr_bits;

  // Fills are always block-aligned, so the I-side offset bits carry no information.
  assign unused_addr_bits = ^icache_addr[OFF_W-1:0];

  assign fill_active = (state_q == I_FILL) || (state_q == D_FILL);
  assign fill_ret    = fill_active && mem_data_valid && (rtn_cnt_q < CNT_WORDS);
  assign grant_i     = icache_req && (!dcache_req || last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      iss_cnt_q    <= '0;
      rtn_cnt_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      iss_cnt_q    <= iss_cnt_d;
      rtn_cnt_q    <= rtn_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    iss_cnt_d      = iss_cnt_q;
    rtn_cnt_d      = rtn_cnt_q;
    last_grant_d   = last_grant_q;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    icache_fill_we = 1'b0;
    dcache_fill_we = 1'b0;
    icache_done    = 1'b0;
    dcache_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (icache_req || dcache_req) begin
          base_d       = grant_i ? icache_addr[ADDR_W-1:OFF_W] : dcache_addr[ADDR_W-1:OFF_W];
          iss_cnt_d    = '0;
          rtn_cnt_d    = '0;
          last_grant_d = !grant_i;
          if (grant_i)        state_d = I_FILL;
          else if (dcache_wr) state_d = D_WRITE;
          else                state_d = D_FILL;
        end
      end

      // Issue and return run independently; only the last returned word ends the fill.
      I_FILL, D_FILL: begin
        if (iss_cnt_q < CNT_WORDS) begin
          mem_enable = 1'b1;
          mem_addr   = {base_q, iss_cnt_q[IDX_W-1:0], 1'b0};
          iss_cnt_d  = iss_cnt_q + CNT_ONE;
        end
        if (fill_ret) begin
          icache_fill_we = (state_q == I_FILL);
          dcache_fill_we = (state_q == D_FILL);
          rtn_cnt_d      = rtn_cnt_q + CNT_ONE;
          if (rtn_cnt_q == CNT_LAST) begin
            icache_done = (state_q == I_FILL);
            dcache_done = (state_q == D_FILL);
            state_d     = IDLE;
          end
        end
      end

      D_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = dcache_addr;
        mem_wdata   = dcache_wdata;
        dcache_done = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign fill_addr   = {base_q, rtn_cnt_q[IDX_W-1:0], 1'b0};
  assign fill_data   = mem_rdata;
  assign icache_busy = icache_req & ~icache_done;
  assign dcache_busy = dcache_req & ~dcache_done;

endmodule
